regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter for the 32-entry, two-write-port register file. It collects register write requests from `nreq` independent producers (ALU, load unit, multiplier, branch/link unit) and grants up to two per cycle in round-robin order. Granted writes are registered onto the register file's `wa0/wd0`, `wa1/wd1` and `write[1:0]` ports. It also suppresses writes to the status register and PC while those registers are being updated by their dedicated paths, and publishes a pending-write bitmap that issue logic uses for hazard stalls.

## Interface
Parameters:
- `nreq`, 4: number of requesters; 2..8.
- `addrsize`, 5: register address width.
- `st_addr`, 28: status register address.
- `pc_addr`, 31: program counter address.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  nreq  per-requester write request.
- `req_addr`  in  nreq*addrsize  destination address; requester i uses bits [i*addrsize +: addrsize].
- `req_data`  in  nreq*32  write data; requester i uses bits [i*32 +: 32].
- `req_ready`  out  nreq  grant; a transfer occurs on a rising edge where valid&ready.
- `st_hold`  in  1  dedicated status write (`stwr`) is active this cycle; requests to `st_addr` are ineligible.
- `pc_hold`  in  1  dedicated PC update (`pcincr`) is active this cycle; requests to `pc_addr` are ineligible.
- `wa0`, `wa1`  out  addrsize  registered write addresses to the register file.
- `wd0`, `wd1`  out  32  registered write data.
- `write`  out  2  registered write enables.
- `pend`  out  32  one-hot-per-address bitmap of writes currently on `wa*/write`.

## Operation
- A requester is eligible when all of the following hold:
  - `req_valid[i]`,
  - not (`req_addr_i == st_addr` && `st_hold`),
  - not (`req_addr_i == pc_addr` && `pc_hold`).
- Round-robin pointer `rr`, range 0..nreq-1.
- Selection is combinational:
  - Scan indices `rr, rr+1, …` modulo nreq.
  - The first eligible requester wins slot 0.
  - The next eligible requester whose address differs from slot 0's wins slot 1.
  - At most two grants per cycle; never two grants to the same address.
- `req_ready[i]` = 1 only for the winners. It depends only on the current inputs and `rr`; requesters must not make `req_valid` depend on `req_ready`.
- Registered output stage:
  - Slot 0 loads `wa0/wd0` and sets `write[0]`.
  - Slot 1 loads `wa1/wd1` and sets `write[1]`.
  - An unused slot clears its `write` bit; `wa/wd` hold their previous values.
  - A single grant always uses slot 0: `write` = 2'b01, never 2'b10.
- `pend` is the decode of the output stage: bit `wa0` set if `write[0]`, bit `wa1` set if `write[1]`.
- Pointer update:
  - On any grant, `rr` <= (index of the last granted requester + 1) mod nreq.
  - With no grant, `rr` is unchanged.
- A requester holding `req_valid` with stable addr/data while not granted is required protocol. The arbiter keeps no copy of ungranted requests.
- Reset values:
  - `rr`=0, `write`=2'b00, `wa0`=`wa1`=0, `wd0`=`wd1`=0, `pend`=0.
  - `req_ready` reflects combinational selection with `rr`=0.
- Reset mid-operation: a write held in the output stage is discarded. The requester already saw its transfer complete and does not retry.

## Timing
- Transfer at edge N → write visible on `wa*/wd*/write/pend` during cycle N+1 → committed in the register file at edge N+1.
- Throughput: 2 writes/cycle sustained when at least two eligible requesters target distinct addresses.
- `st_hold`/`pc_hold` act in the same cycle; a blocked request becomes grantable the first cycle the hold is low.
- Fairness: a continuously eligible requester is granted within `nreq-1` cycles.
- Write-port ordering: the register file gives `write[1]` precedence on equal addresses. The distinct-address rule makes that ordering irrelevant.

## Structure
- Shared package `cpu32_regs_pkg`: `st_addr`, `lr_addr`, `sp_addr`, `pc_addr`, `addrsize`, `gpregsnum`. The register file and this block both use it.
- One sub-module `rr_pick2`: combinational two-winner round-robin selector taking the eligible vector, addresses and pointer; it outputs the two winner indices and valid bits.
- The top level holds `rr`, the output stage and the `pend` decode.

## Test plan
- Reset, then nreq=4, requesters 0 and 2 valid, addr 3 / 7, data 0xA / 0xB:
  - ready=0101.
  - Next cycle wa0=3, wd0=0xA, wa1=7, wd1=0xB, write=11, pend=0x88.
  - rr=3.
- Requesters 1 and 3 both target addr 5, rr=0:
  - Only requester 1 is granted; write=01.
  - Requester 3 is granted the following cycle with rr=2.
- All four valid on distinct addresses for 4 cycles:
  - Grant pairs (0,1), (2,3), (0,1), (2,3).
- Requester 0 targets addr 28 with st_hold=1 and requester 1 targets addr 4:
  - Only requester 1 is granted.
  - Drop st_hold → requester 0 is granted next cycle.
- Requester 0 targets addr 31 with pc_hold=1 for 3 cycles:
  - ready[0]=0 throughout, write=00.
  - Granted in the first cycle pc_hold=0.
- Assert rst asynchronously mid-cycle while write=11:
  - write, wa*, wd*, pend drop to 0 immediately.
  - rr=0 after release.

Source files
------------

// File: rtl/cpu32_regs_pkg.sv
// Register-file constants shared by the register file and its write-back arbiter.
package cpu32_regs_pkg;
  localparam int addrsize  = 5;
  localparam int regsnum   = 32;
  localparam int gpregsnum = 28;
  localparam int st_addr   = 28;
  localparam int sp_addr   = 29;
  localparam int lr_addr   = 30;
  localparam int pc_addr   = 31;

  // One-hot bit for a register address, used for hazard bitmaps.
  function automatic logic [regsnum-1:0] reg_bit(input int unsigned a);
    logic [regsnum-1:0] v;
    v = '0;
    v[a % regsnum] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Combinational two-winner round-robin selector; the second winner must target
// a different address from the first.
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]    elig_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [IW-1:0]      rr_i,
  output logic [IW-1:0]      idx0_o,
  output logic [IW-1:0]      idx1_o,
  output logic               vld0_o,
  output logic               vld1_o
);
  always_comb begin
    int j;
    logic [AW-1:0] a0;
    vld0_o = 1'b0;
    vld1_o = 1'b0;
    idx0_o = '0;
    idx1_o = '0;
    a0     = '0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_i) + k) % NREQ;
      if (elig_i[j]) begin
        if (!vld0_o) begin
          vld0_o = 1'b1;
          idx0_o = IW'(j);
          a0     = addr_i[j*AW +: AW];
        end else if (!vld1_o && addr_i[j*AW +: AW] != a0) begin
          vld1_o = 1'b1;
          idx1_o = IW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: grants up to two register writes per cycle round-robin and
// registers them onto the two register-file write ports.
module regfile_wb_arbiter #(
  parameter int nreq     = 4,
  parameter int addrsize = cpu32_regs_pkg::addrsize,
  parameter int st_addr  = cpu32_regs_pkg::st_addr,
  parameter int pc_addr  = cpu32_regs_pkg::pc_addr
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [nreq-1:0]          req_valid,
  input  logic [nreq*addrsize-1:0] req_addr,
  input  logic [nreq*32-1:0]       req_data,
  output logic [nreq-1:0]          req_ready,
  input  logic                     st_hold,
  input  logic                     pc_hold,
  output logic [addrsize-1:0]      wa0,
  output logic [addrsize-1:0]      wa1,
  output logic [31:0]              wd0,
  output logic [31:0]              wd1,
  output logic [1:0]               write,
  output logic [31:0]              pend
);
  import cpu32_regs_pkg::*;

  localparam int IW = $clog2(nreq);

  logic [nreq-1:0]     elig;
  logic [IW-1:0]       idx0, idx1;
  logic                vld0, vld1;
  logic [IW-1:0]       rr_q, rr_d;
  logic [1:0]          write_q, write_d;
  logic [addrsize-1:0] wa0_q, wa0_d, wa1_q, wa1_d;
  logic [31:0]         wd0_q, wd0_d, wd1_q, wd1_d;

  // Requests to st/pc are masked while their dedicated update paths own them.
  always_comb begin
    logic [addrsize-1:0] a;
    elig = '0;
    a    = '0;
    for (int i = 0; i < nreq; i++) begin
      a = req_addr[i*addrsize +: addrsize];
      elig[i] = req_valid[i]
                && !(st_hold && a == addrsize'(st_addr))
                && !(pc_hold && a == addrsize'(pc_addr));
    end
  end

  rr_pick2 #(.NREQ(nreq), .AW(addrsize), .IW(IW)) u_pick (
    .elig_i (elig),
    .addr_i (req_addr),
    .rr_i   (rr_q),
    .idx0_o (idx0),
    .idx1_o (idx1),
    .vld0_o (vld0),
    .vld1_o (vld1)
  );

  always_comb begin
    int last;
    req_ready = '0;
    if (vld0) req_ready[idx0] = 1'b1;
    if (vld1) req_ready[idx1] = 1'b1;

    write_d = {vld1, vld0};
    wa0_d   = vld0 ? req_addr[int'(idx0)*addrsize +: addrsize] : wa0_q;
    wd0_d   = vld0 ? req_data[int'(idx0)*32 +: 32] : wd0_q;
    wa1_d   = vld1 ? req_addr[int'(idx1)*addrsize +: addrsize] : wa1_q;
    wd1_d   = vld1 ? req_data[int'(idx1)*32 +: 32] : wd1_q;

    // Pointer moves past the last winner so it gets lowest priority next.
    last = vld1 ? int'(idx1) : int'(idx0);
    rr_d = rr_q;
    if (vld0) rr_d = (last == nreq - 1) ? '0 : IW'(last + 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= '0;
      write_q <= '0;
      wa0_q   <= '0;
      wa1_q   <= '0;
      wd0_q   <= '0;
      wd1_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      write_q <= write_d;
      wa0_q   <= wa0_d;
      wa1_q   <= wa1_d;
      wd0_q   <= wd0_d;
      wd1_q   <= wd1_d;
    end
  end

  assign wa0   = wa0_q;
  assign wa1   = wa1_q;
  assign wd0   = wd0_q;
  assign wd1   = wd1_q;
  assign write = write_q;
  assign pend  = (write_q[0] ? reg_bit(int'(wa0_q)) : '0)
               | (write_q[1] ? reg_bit(int'(wa1_q)) : '0);
endmodule
